// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
// The PC drives instruction memory directly; read data is captured into IF/ID on the next edge.
module instruction_fetch #(
  parameter int INS_ADDRESS = 32,
  parameter int INS_W       = 32,
  parameter int RESET_PC    = 0,
  parameter int IMEM_LAST   = 68
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_en,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic [INS_ADDRESS-1:0] imem_address,
  input  logic [INS_W-1:0]       imem_instruction,
  output logic [INS_ADDRESS-1:0] if_id_pc,
  output logic [INS_ADDRESS-1:0] if_id_pc_plus4,
  output logic [INS_W-1:0]       if_id_instruction,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [INS_ADDRESS-1:0] RESET_PC_A  = INS_ADDRESS'(RESET_PC);
  localparam logic [INS_ADDRESS-1:0] IMEM_LAST_A = INS_ADDRESS'(IMEM_LAST);
  localparam logic [INS_W-1:0]       NOP         = INS_W'(32'h00000013);

  state_t                   state_q, state_d;
  logic [INS_ADDRESS-1:0]   pc_q, pc_d;
  logic [INS_ADDRESS-1:0]   ifid_pc_q, ifid_pc_d;
  logic [INS_ADDRESS-1:0]   ifid_pc4_q, ifid_pc4_d;
  logic [INS_W-1:0]         ifid_instr_q, ifid_instr_d;
  logic                     ifid_valid_q, ifid_valid_d;
  logic [31:0]              count_q, count_d;

  logic [INS_ADDRESS-1:0]   pc_plus4;
  logic [INS_ADDRESS-1:0]   target_pc;
  logic                     do_bubble;
  logic                     do_latch;

  // Adder width equals the PC width, so the increment wraps silently.
  assign pc_plus4  = pc_q + INS_ADDRESS'(4);
  assign target_pc = redirect_pc & ~INS_ADDRESS'(3);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    do_bubble    = 1'b0;
    do_latch     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d   = RUN;
        do_bubble = 1'b1;
      end
      RUN: begin
        if (redirect_en) begin
          pc_d      = target_pc;
          do_bubble = 1'b1;
        end else if (pc_q > IMEM_LAST_A) begin
          state_d   = HALT;
          do_bubble = 1'b1;
        end else begin
          if (!stall) pc_d = pc_plus4;
          // Flush wins over stall for IF/ID, while the PC still honours the stall.
          if (flush)       do_bubble = 1'b1;
          else if (!stall) do_latch  = 1'b1;
        end
      end
      HALT: begin
        do_bubble = 1'b1;
        if (redirect_en) begin
          state_d = RUN;
          pc_d    = target_pc;
        end
      end
      default: begin
        state_d   = BOOT;
        do_bubble = 1'b1;
      end
    endcase

    if (do_bubble) begin
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
    end else if (do_latch) begin
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = imem_instruction;
      ifid_valid_d = 1'b1;
    end

    if (do_latch && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC_A;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
    end
  end

  assign imem_address      = pc_q;
  assign if_id_pc          = ifid_pc_q;
  assign if_id_pc_plus4    = ifid_pc4_q;
  assign if_id_instruction = ifid_instr_q;
  assign if_id_valid       = ifid_valid_q;
  assign halted            = (state_q == HALT);
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, stall, flush, redirect, halt and async reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .redirect_en       (redirect_en),
    .redirect_pc       (redirect_pc),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .halted            (halted),
    .fetch_count       (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory model: word 0 holds addi x1,x0,1; every other word is tagged with its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'd0) ? 32'h00100093 : (32'hA000_0000 | a);
  endfunction

  assign imem_instruction = mem(imem_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic v);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, v});
    check({tag, " pc"}, if_id_pc, v ? pc : 32'd0);
    check({tag, " pc4"}, if_id_pc_plus4, v ? pc + 32'd4 : 32'd0);
    check({tag, " instr"}, if_id_instruction, v ? mem(pc) : 32'h00000013);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    step(); step();
    $display("reset held");
    check_ifid("rst", 32'd0, 1'b0);
    check("rst count", fetch_count, 32'd0);
    check("rst halted", {31'd0, halted}, 32'd0);
    check("rst addr", imem_address, 32'd0);

    reset = 1'b0;
    step();
    $display("boot edge: addr=%0h valid=%0b", imem_address, if_id_valid);
    check_ifid("boot", 32'd0, 1'b0);
    check("boot addr", imem_address, 32'd0);
    step();
    $display("first latch: pc=%0h instr=%08h", if_id_pc, if_id_instruction);
    check_ifid("first", 32'd0, 1'b1);
    check("first count", fetch_count, 32'd1);
    check("first addr", imem_address, 32'd4);
    step();
    check_ifid("second", 32'd4, 1'b1);
    check("second addr", imem_address, 32'd8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("stall cycle %0d: addr=%0h pc=%0h", i, imem_address, if_id_pc);
      check("stall addr", imem_address, 32'd8);
      check_ifid("stall", 32'd4, 1'b1);
      check("stall count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    step();
    check_ifid("post stall", 32'd8, 1'b1);
    check("post stall count", fetch_count, 32'd3);
    check("post stall addr", imem_address, 32'd12);

    flush = 1'b1; stall = 1'b1;
    step();
    $display("flush+stall: addr=%0h valid=%0b", imem_address, if_id_valid);
    check_ifid("flush", 32'd0, 1'b0);
    check("flush addr", imem_address, 32'd12);
    check("flush count", fetch_count, 32'd3);
    flush = 1'b0; stall = 1'b0;
    step();
    check_ifid("post flush", 32'd12, 1'b1);
    step();
    check_ifid("pc16", 32'd16, 1'b1);
    check("pc16 count", fetch_count, 32'd5);
    check("pc20 addr", imem_address, 32'd20);

    redirect_en = 1'b1; redirect_pc = 32'h1E; stall = 1'b1;
    step();
    $display("redirect+stall: addr=%0h valid=%0b", imem_address, if_id_valid);
    check("redir addr", imem_address, 32'h1C);
    check_ifid("redir", 32'd0, 1'b0);
    check("redir count", fetch_count, 32'd5);
    redirect_en = 1'b0; stall = 1'b0;
    step();
    check_ifid("post redir", 32'h1C, 1'b1);
    check("post redir count", fetch_count, 32'd6);

    for (int a = 32; a <= 68; a += 4) begin
      step();
      $display("run latch pc=%0h count=%0d", if_id_pc, fetch_count);
      check_ifid("run", 32'(a), 1'b1);
    end
    check("run count", fetch_count, 32'd16);
    check("run addr", imem_address, 32'd72);
    step();
    $display("halt: halted=%0b addr=%0h", halted, imem_address);
    check("halt flag", {31'd0, halted}, 32'd1);
    check("halt addr", imem_address, 32'd72);
    check_ifid("halt", 32'd0, 1'b0);
    step();
    check("halt hold flag", {31'd0, halted}, 32'd1);
    check("halt hold addr", imem_address, 32'd72);
    check("halt count", fetch_count, 32'd16);

    redirect_en = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_en = 1'b0;
    $display("restart: halted=%0b addr=%0h", halted, imem_address);
    check("restart flag", {31'd0, halted}, 32'd0);
    check("restart addr", imem_address, 32'd0);
    check_ifid("restart", 32'd0, 1'b0);
    step();
    check_ifid("restart latch", 32'd0, 1'b1);
    check("restart count", fetch_count, 32'd17);

    // Redirect near the top of the address space: wrapped/out-of-range PC must halt.
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    step();
    redirect_en = 1'b0;
    check("hi addr", imem_address, 32'hFFFF_FFFC);
    check("hi not halted", {31'd0, halted}, 32'd0);
    step();
    $display("high pc: halted=%0b addr=%0h", halted, imem_address);
    check("hi halted", {31'd0, halted}, 32'd1);
    check("hi hold", imem_address, 32'hFFFF_FFFC);

    redirect_en = 1'b1; redirect_pc = 32'd40;
    step();
    check("pre async addr", imem_address, 32'd40);
    redirect_pc = 32'd60;
    #2 reset = 1'b1;
    #1;
    $display("async reset: addr=%0h valid=%0b count=%0d", imem_address, if_id_valid, fetch_count);
    check("async addr", imem_address, 32'd0);
    check("async count", fetch_count, 32'd0);
    check("async halted", {31'd0, halted}, 32'd0);
    check_ifid("async", 32'd0, 1'b0);
    step();
    redirect_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    check_ifid("rel boot", 32'd0, 1'b0);
    step();
    $display("after release: pc=%0h count=%0d", if_id_pc, fetch_count);
    check_ifid("rel latch", 32'd0, 1'b1);
    check("rel count", fetch_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 32: width of the PC and instruction-memory address.
REQ-002 SHALL have parameter INS_W, default 32: instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 SHALL have parameter IMEM_LAST, default 68: highest valid word-aligned byte address in instruction memory.
REQ-005 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-006 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-008 SHALL have port flush  input  1  replace the IF/ID contents with a bubble.
REQ-009 SHALL have port redirect_en  input  1  load redirect_pc into the PC (branch/jump taken).
REQ-010 SHALL have port redirect_pc  input  INS_ADDRESS  target byte address.
REQ-011 SHALL have port imem_address  output  INS_ADDRESS  read address to instruction memory.
REQ-012 SHALL have port imem_instruction  input  INS_W  combinational read data from instruction memory.
REQ-013 SHALL have port if_id_pc  output  INS_ADDRESS  PC of the instruction held in IF/ID.
REQ-014 SHALL have port if_id_pc_plus4  output  INS_ADDRESS  if_id_pc + 4.
REQ-015 SHALL have port if_id_instruction  output  INS_W  instruction held in IF/ID.
REQ-016 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 SHALL have port halted  output  1  fetch is in HALT.
REQ-018 SHALL have port fetch_count  output  32  number of instructions latched valid into IF/ID since reset.

Function
REQ-019 SHALL drive imem_address combinationally equal to the PC register.
REQ-020 SHALL implement FSM states BOOT, RUN and HALT; reset enters BOOT.
REQ-021 BOOT SHALL last exactly one cycle, with the IF/ID register bubbled and the PC unchanged, then go to RUN.
REQ-022 In RUN, when PC > IMEM_LAST and redirect_en=0 at a clock edge, SHALL go to HALT, hold the PC and write a bubble into IF/ID.
REQ-023 HALT SHALL be left only by redirect_en=1 (to RUN) or by reset.
REQ-024 PC next-state priority SHALL be: redirect_en (PC <= redirect_pc with bits [1:0] forced to 0), then HALT/stall (hold), else PC <= PC + 4.
REQ-025 PC + 4 SHALL wrap modulo 2^INS_ADDRESS with no error signalled; the wrapped PC is subject to REQ-022.
REQ-026 IF/ID priority SHALL be: redirect_en or flush -> bubble, then stall -> hold, else latch.
REQ-027 Latch SHALL capture PC, PC + 4, imem_instruction and valid=1 (RUN only).
REQ-028 Bubble SHALL set valid=0, instruction=32'h00000013 (NOP), pc=0 and pc_plus4=0.
REQ-029 redirect_en with stall in the same cycle SHALL load the PC with the target and bubble IF/ID; redirect overrides stall.
REQ-030 flush with stall in the same cycle SHALL bubble IF/ID and hold the PC.
REQ-031 fetch_count SHALL increment by 1 on each edge that performs a latch with valid=1, and SHALL saturate at 32'hFFFFFFFF.
REQ-032 halted SHALL be 1 exactly while the FSM is in HALT.
REQ-033 Latency: an instruction at PC p presented in cycle n SHALL appear on if_id_* after the edge ending cycle n.

Reset
REQ-034 While reset=1, SHALL force asynchronously: PC=RESET_PC, FSM=BOOT, if_id_valid=0, if_id_instruction=32'h00000013, if_id_pc=0, if_id_pc_plus4=0, fetch_count=0, halted=0.
REQ-035 Reset asserted mid-operation SHALL discard any pending redirect, stall or flush; the first valid latch after release SHALL be at RESET_PC.

Verification
REQ-036 Release reset with memory returning 32'h00100093 at address 0 -> cycle 1 is a bubble; after the 2nd edge, if_id_pc=0, if_id_instruction=32'h00100093, valid=1, fetch_count=1.
REQ-037 Stall held 3 cycles at PC=8 -> imem_address stays 8, if_id_* are unchanged, fetch_count is unchanged; after release the next latch has pc=8.
REQ-038 redirect_en=1 with redirect_pc=0x1E and stall=1 at PC=20 -> next PC=0x1C, IF/ID bubbled (valid=0, instr=0x00000013), next latch pc=0x1C.
REQ-039 Sequential run to PC=72 with IMEM_LAST=68 -> halted=1, PC held at 72, valid=0; a later redirect to 0 restarts fetch and the next latch has pc=0.
REQ-040 flush=1 and stall=1 together at PC=12 -> IF/ID bubbled, PC held at 12.
REQ-041 reset asserted asynchronously mid-cycle while redirect_en=1 -> outputs reach reset values immediately, without waiting for a clock edge; PC=RESET_PC after release.
